// File: rtl/mem_load_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_stage
// Description : MEM pipeline stage for the 5-stage MIPS core. It works with a
//               request/response data port. It stalls for an outstanding load
//               response and buffers a response that arrives while WB is
//               stalled. After a flush it discards orphaned responses. It also
//               aligns load data (lb/lbu/lh/lhu/lw/lwl/lwr) and produces the
//               per-byte register write enables.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_stage #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic        clk,
    input  logic        resetn,

    // EX -> MEM
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic        es_req_sent,
    input  logic [2:0]  es_ld_op,
    input  logic        es_gr_we,
    input  logic [4:0]  es_dest,
    input  logic [31:0] es_result,
    input  logic [31:0] es_pc,
    input  logic        es_ex,
    input  logic [4:0]  es_excode,
    input  logic        es_eret,
    input  logic        es_bd,

    // data port response
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,

    // MEM -> WB
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [3:0]  ms_rf_we,
    output logic [4:0]  ms_dest,
    output logic [31:0] ms_final_result,
    output logic [31:0] ms_pc,
    output logic        ms_ex,
    output logic [4:0]  ms_excode,
    output logic        ms_eret,
    output logic        ms_bd,

    // forwarding / control
    output logic        ms_fwd_valid,
    output logic        ms_fwd_ready,
    output logic        ms_flush,
    input  logic        flush,
    output logic        ms_discard_busy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam logic [2:0] c_LD_NONE = 3'd0;
    localparam logic [2:0] c_LD_W    = 3'd1;
    localparam logic [2:0] c_LD_B    = 3'd2;
    localparam logic [2:0] c_LD_BU   = 3'd3;
    localparam logic [2:0] c_LD_H    = 3'd4;
    localparam logic [2:0] c_LD_HU   = 3'd5;
    localparam logic [2:0] c_LD_WL   = 3'd6;
    localparam logic [2:0] c_LD_WR   = 3'd7;

    // Two spare bits so the flush arithmetic (+2 worst case) cannot wrap
    // before saturation is applied.
    localparam int                 c_SUM_W   = CNT_W + 2;
    localparam logic [c_SUM_W-1:0] c_SUM_MAX = c_SUM_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]   c_CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    // state and latched EX bundle
    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_ld_op;
    logic               r_gr_we;
    logic [4:0]         r_dest;
    logic [31:0]        r_result;
    logic [31:0]        r_pc;
    logic               r_ex;
    logic [4:0]         r_excode;
    logic               r_eret;
    logic               r_bd;

    // early-response buffer and orphan counter
    logic               r_buf_valid;
    logic [31:0]        r_buf_data;
    logic [CNT_W-1:0]   r_discard_cnt;

    // combinational helpers
    logic               w_ms_valid;
    logic               w_wait_st;
    logic               w_is_load;
    logic               w_cnt_zero;
    logic               w_dec;
    logic               w_attr;
    logic               w_ready_go;
    logic               w_accept_es;
    logic [c_SUM_W-1:0] w_cnt_sum;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        w_rdata;
    logic [1:0]         w_lo;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_aligned;
    logic [3:0]         w_rf_we;

    assign w_ms_valid = (r_state != S_EMPTY);
    assign w_wait_st  = (r_state == S_WAIT);
    assign w_is_load  = (r_ld_op != c_LD_NONE);
    assign w_cnt_zero = (r_discard_cnt == '0);

    // A response goes first to an outstanding orphan; only when none remain
    // can it belong to the load waiting here. Anything else is dropped.
    assign w_dec  = data_data_ok && !w_cnt_zero;
    assign w_attr = data_data_ok && w_cnt_zero && w_wait_st;

    // State register for the EMPTY / WAIT / READY occupancy machine
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake outputs and next-state selection
    always_comb begin
        w_ready_go     = !w_wait_st || w_attr;
        ms_allowin     = !w_ms_valid || (w_ready_go && ws_allowin);
        ms_to_ws_valid = w_ms_valid && w_ready_go && !flush;
        w_accept_es    = es_to_ms_valid && ms_allowin;
        w_state_nxt    = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else if (w_accept_es) begin
            // only a load whose request actually went out has a response to wait for
            if ((es_ld_op != c_LD_NONE) && es_req_sent) begin
                w_state_nxt = S_WAIT;
            end else begin
                w_state_nxt = S_READY;
            end
        end else if (ms_allowin) begin
            w_state_nxt = S_EMPTY;
        end else if (w_attr) begin
            w_state_nxt = S_READY;
        end
    end

    // Capture the EX bundle whenever an instruction enters the stage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ld_op  <= c_LD_NONE;
            r_gr_we  <= 1'b0;
            r_dest   <= 5'd0;
            r_result <= 32'd0;
            r_pc     <= 32'd0;
            r_ex     <= 1'b0;
            r_excode <= 5'd0;
            r_eret   <= 1'b0;
            r_bd     <= 1'b0;
        end else if (w_accept_es) begin
            r_ld_op  <= es_ld_op;
            r_gr_we  <= es_gr_we;
            r_dest   <= es_dest;
            r_result <= es_result;
            r_pc     <= es_pc;
            r_ex     <= es_ex;
            r_excode <= es_excode;
            r_eret   <= es_eret;
            r_bd     <= es_bd;
        end
    end

    // Hold a response that WB could not take in its arrival cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= 32'd0;
        end else if (flush) begin
            r_buf_valid <= 1'b0;
        end else if (w_attr && !ws_allowin) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= data_rdata;
        end else if (w_ms_valid && ms_allowin) begin
            r_buf_valid <= 1'b0;
        end
    end

    // Orphan count: decrement on every consumed response, and on flush add
    // the request(s) whose responses will now arrive with no owner.
    always_comb begin
        w_cnt_sum = {2'b00, r_discard_cnt} - c_SUM_W'(w_dec);
        if (flush) begin
            w_cnt_sum = w_cnt_sum
                      + c_SUM_W'(w_wait_st && !w_attr)
                      + c_SUM_W'(es_to_ms_valid && es_req_sent && ms_allowin);
        end
        if (w_cnt_sum > c_SUM_MAX) begin
            w_cnt_nxt = c_CNT_MAX;
        end else begin
            w_cnt_nxt = w_cnt_sum[CNT_W-1:0];
        end
    end

    // Orphan counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_discard_cnt <= '0;
        end else begin
            r_discard_cnt <= w_cnt_nxt;
        end
    end

    // Load data alignment from the buffered or live response word
    always_comb begin
        w_rdata = r_buf_valid ? r_buf_data : data_rdata;
        w_lo    = r_result[1:0];
        case (w_lo)
            2'd0:    w_byte = w_rdata[7:0];
            2'd1:    w_byte = w_rdata[15:8];
            2'd2:    w_byte = w_rdata[23:16];
            default: w_byte = w_rdata[31:24];
        endcase
        w_half    = w_lo[1] ? w_rdata[31:16] : w_rdata[15:0];
        w_aligned = w_rdata;
        case (r_ld_op)
            c_LD_B:  w_aligned = {{24{w_byte[7]}}, w_byte};
            c_LD_BU: w_aligned = {24'd0, w_byte};
            c_LD_H:  w_aligned = {{16{w_half[15]}}, w_half};
            c_LD_HU: w_aligned = {16'd0, w_half};
            c_LD_WL: begin
                case (w_lo)
                    2'd0:    w_aligned = {w_rdata[7:0],  24'd0};
                    2'd1:    w_aligned = {w_rdata[15:0], 16'd0};
                    2'd2:    w_aligned = {w_rdata[23:0], 8'd0};
                    default: w_aligned = w_rdata;
                endcase
            end
            c_LD_WR: begin
                case (w_lo)
                    2'd0:    w_aligned = w_rdata;
                    2'd1:    w_aligned = {8'd0,  w_rdata[31:8]};
                    2'd2:    w_aligned = {16'd0, w_rdata[31:16]};
                    default: w_aligned = {24'd0, w_rdata[31:24]};
                endcase
            end
            c_LD_W:  w_aligned = w_rdata;
            default: w_aligned = w_rdata;
        endcase
    end

    // Per-byte write enables: lwl/lwr only touch the bytes they merge
    always_comb begin
        w_rf_we = {4{r_gr_we}};
        if (r_ld_op == c_LD_WL) begin
            w_rf_we = {1'b1, w_lo != 2'd0, w_lo[1], w_lo == 2'd3};
        end else if (r_ld_op == c_LD_WR) begin
            w_rf_we = {w_lo == 2'd0, !w_lo[1], w_lo != 2'd3, 1'b1};
        end
    end

    assign ms_rf_we        = w_ms_valid ? w_rf_we : 4'd0;
    assign ms_dest         = r_dest;
    assign ms_final_result = w_is_load ? w_aligned : r_result;
    assign ms_pc           = r_pc;
    assign ms_ex           = w_ms_valid && r_ex;
    assign ms_excode       = w_ms_valid ? r_excode : 5'd0;
    assign ms_eret         = w_ms_valid && r_eret;
    assign ms_bd           = w_ms_valid && r_bd;
    assign ms_fwd_valid    = w_ms_valid && r_gr_we;
    assign ms_fwd_ready    = w_ms_valid && w_ready_go;
    assign ms_flush        = w_ms_valid && (r_ex || r_eret);
    assign ms_discard_busy = !w_cnt_zero || (r_discard_cnt == c_CNT_MAX);

endmodule
`default_nettype wire
